// File: rtl/imm_pkg.sv
// Shared definitions for the immediate encoder: immsrc coding and
// instruction bit positions of each immediate field.
package imm_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  // I-type: [31:20]
  localparam int I_LSB    = 20;
  // S-type: [31:25], [11:7]
  localparam int S_HI_LSB = 25;
  localparam int S_LO_LSB = 7;
  // B-type: [31], [30:25], [11:8], [7]
  localparam int B_SGN    = 31;
  localparam int B_HI_LSB = 25;
  localparam int B_LO_LSB = 8;
  localparam int B_B11    = 7;
  // J-type: [31], [30:21], [20], [19:12]
  localparam int J_SGN    = 31;
  localparam int J_LO_LSB = 21;
  localparam int J_B11    = 20;
  localparam int J_HI_LSB = 12;

  // Highest immediate bit that still lands in the word
  localparam int IS_TOP = 11;
  localparam int B_TOP  = 12;
  localparam int J_TOP  = 20;

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: scatters an immediate into a template word
// and reports whether the value is representable in that format.
import imm_pkg::*;

module imm_pack #(
  parameter int I_WIDTH = 32,
  parameter int D_WIDTH = 32
) (
  input  logic [I_WIDTH-1:0] tmpl,
  input  logic [D_WIDTH-1:0] imm,
  input  logic [1:0]         immsrc,
  output logic [I_WIDTH-1:0] word,
  output logic               ok
);

  function automatic logic fits(
    input logic [D_WIDTH-1:0] v,
    input int                 top
  );
    logic r;
    r = 1'b1;
    for (int i = 0; i < D_WIDTH; i++)
      if (i > top && v[i] != v[top])
        r = 1'b0;
    return r;
  endfunction

  always_comb begin
    word = tmpl;
    ok   = 1'b0;
    unique case (imm_src_e'(immsrc))
      IMM_I: begin
        word[I_LSB +: 12] = imm[11:0];
        ok = fits(imm, IS_TOP);
      end
      IMM_S: begin
        word[S_HI_LSB +: 7] = imm[11:5];
        word[S_LO_LSB +: 5] = imm[4:0];
        ok = fits(imm, IS_TOP);
      end
      IMM_B: begin
        word[B_SGN]         = imm[12];
        word[B_HI_LSB +: 6] = imm[10:5];
        word[B_LO_LSB +: 4] = imm[4:1];
        word[B_B11]         = imm[11];
        ok = fits(imm, B_TOP) && !imm[0];
      end
      IMM_J: begin
        word[J_SGN]          = imm[20];
        word[J_LO_LSB +: 10] = imm[10:1];
        word[J_B11]          = imm[11];
        word[J_HI_LSB +: 8]  = imm[19:12];
        ok = fits(imm, J_TOP) && !imm[0];
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: packs requests into instruction words and streams
// them to instruction memory with an auto-incrementing word address.
import imm_pkg::*;

module imm_encoder #(
  parameter int          I_WIDTH   = 32,
  parameter int          D_WIDTH   = 32,
  parameter int          A_WIDTH   = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         immsrc,
  input  logic [D_WIDTH-1:0] imm,
  input  logic [I_WIDTH-1:0] tmpl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_WIDTH-1:0] wr_addr,
  output logic [I_WIDTH-1:0] wr_data,
  output logic               range_err,
  output logic [7:0]         err_count,
  output logic               wrapped
);

  localparam logic [A_WIDTH-1:0] BASE = A_WIDTH'(BASE_ADDR);

  logic [I_WIDTH-1:0] word;
  logic               ok;
  logic               accept;
  logic               fire;

  imm_pack #(
    .I_WIDTH (I_WIDTH),
    .D_WIDTH (D_WIDTH)
  ) u_pack (
    .tmpl   (tmpl),
    .imm    (imm),
    .immsrc (immsrc),
    .word   (word),
    .ok     (ok)
  );

  assign in_ready = !rst && !clr
                 && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign fire     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      out_valid <= 1'b0;
      wr_addr   <= BASE;
      wr_data   <= '0;
      range_err <= 1'b0;
      err_count <= '0;
      wrapped   <= 1'b0;
    end else begin
      range_err <= accept && !ok;
      // rejected requests never touch the output register
      if (accept && ok) begin
        out_valid <= 1'b1;
        wr_data   <= word;
      end else if (fire) begin
        out_valid <= 1'b0;
      end
      if (accept && !ok && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
      if (fire) begin
        wr_addr <= wr_addr + 1'b1;
        if (&wr_addr)
          wrapped <= 1'b1;
      end
    end
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the core's immediate sign-extension path: packs a 32-bit immediate into the I/S/B/J bit positions of a RISC-V instruction template.
- Range-checks the immediate before packing.
- Streams encoded words into the instruction-memory write port with an auto-incrementing word address.
- Used by the program loader / test-program builder ahead of instruction memory.

Parameters:
I_WIDTH, 32, instruction word width
D_WIDTH, 32, immediate width
A_WIDTH, 10, instruction-memory word-address width
BASE_ADDR, 0, word address loaded on reset and on clr

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
clr  input  1  synchronous soft clear: pipeline flush, address to BASE_ADDR, flags cleared
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid && in_ready
immsrc  input  2  00 I, 01 S, 10 B, 11 J
imm  input  D_WIDTH  signed immediate (byte offset for B/J)
tmpl  input  I_WIDTH  instruction template; immediate bit positions are ignored
out_valid  output  1  wr_addr/wr_data valid
out_ready  input  1  memory accepts the word
wr_addr  output  A_WIDTH  word address
wr_data  output  I_WIDTH  encoded instruction
range_err  output  1  one-cycle pulse: accepted request rejected
err_count  output  8  saturating count of rejected requests
wrapped  output  1  sticky: address wrapped past 2^A_WIDTH-1

Behaviour:
- Reset is synchronous on rst and has top priority. Reset values: out_valid=0, wr_addr=BASE_ADDR, wr_data=0, range_err=0, err_count=0, wrapped=0.
- clr in a cycle where rst=0 has the same effect as reset. in_ready=0 during clr. Any held word is discarded.
- in_ready = !out_valid || out_ready. The output register is a single stage, so latency is 1 cycle from the accepting edge to out_valid.
- Packing: all non-immediate bits come from tmpl.
  - I: [31:20]=imm[11:0]
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]
  - J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1]
- Range rules: the high immediate bits must all equal the top packed bit.
  - I/S: imm[31:11]
  - B: imm[31:12], and imm[0] must be 0
  - J: imm[31:20], and imm[0] must be 0
- On a range violation at acceptance:
  - range_err=1 in the next cycle only.
  - err_count increments, saturating at 255.
  - out_valid is not set and the output register keeps its previous value. A word still held in the register stays stalled.
  - wr_addr is unchanged.
- Output handshake (out_valid && out_ready):
  - wr_addr increments by 1 on the same edge.
  - At 2^A_WIDTH-1 it wraps to 0 and sets wrapped.
  - A new accept can load the register on that same edge (full throughput, one word per cycle).
- While out_valid=1 and out_ready=0, wr_addr and wr_data hold stable.
- rst or clr mid-stall drops the held word and no write occurs.

Decomposition:
- imm_pkg holds:
  - enum imm_src_e {IMM_I=2'b00, IMM_S=2'b01, IMM_B=2'b10, IMM_J=2'b11}, using the same coding as the core's decode-side immsrc.
  - Field-position localparams for each type.
- Sub-module imm_pack is purely combinational: (tmpl, imm, immsrc) -> (word, ok).
- imm_encoder contains the handshake, output register, address counter and flags.

Test Plan:
- I-type: tmpl=0x00000013, imm=0xFFFFFFFF, immsrc=00, out_ready=1 -> next cycle out_valid=1, wr_data=0xFFF00013, wr_addr=0.
- S then B back-to-back:
  - S: tmpl=0x00002023, imm=0x7FF -> wr_data=0x7E002FA3 @addr0.
  - B: tmpl=0x00000063, imm=0xFFFFFFFC -> wr_data=0xFE000EE3 @addr1, on consecutive cycles.
- Range errors:
  - J imm=3 -> range_err pulse, err_count=1, no write.
  - I imm=2048 -> err_count=2.
  - wr_addr stays 0 throughout.
- Backpressure: accept two words with out_ready=0 for 3 cycles.
  - in_ready=0 after the first accept; the first word is held stable.
  - After release, writes go to addr 0 then addr 1, with no loss or duplication.
- Wrap: A_WIDTH=2, five valid I-type words -> wr_addr sequence 0,1,2,3,0, wrapped=1 after the fifth write.
- clr/rst while stalled (out_valid=1, out_ready=0) -> next cycle out_valid=0, wr_addr=BASE_ADDR, wrapped=0, err_count=0.
